io_dma_port: RTL and testbench

Device-side bus master for the IO port of the DMA block; runs on io_clk. Collects address/data words from a peripheral stream into a FIFO and pushes them to the DMA IO port as fixed 4-beat write bursts, flagging the last beat with io_tx_interrupt. Captures every word the DMA pushes back through io_rx_interrupt cycles and presents it on a registered receive port.

---
 rtl/io_dma_port.sv | 128 ++++++++++++
 tb/tb_io_dma_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_dma_port.sv
// Device-side master for the DMA IO port: stages peripheral words in a FWFT FIFO,
// sends them as 4-beat write bursts and captures words the DMA pushes back.
module io_dma_port #(
  parameter int SZ    = 8,
  parameter int WSZ   = 8,
  parameter int DEPTH = 8
) (
  input  logic                       io_clk,
  input  logic                       rst,
  input  logic                       dev_valid,
  output logic                       dev_ready,
  input  logic [SZ-1:0]              dev_addr,
  input  logic [WSZ-1:0]             dev_data,
  inout  wire  [SZ-1:0]              io_addr,
  inout  wire  [WSZ-1:0]             io_data,
  output logic                       io_w_notr,
  output logic                       io_tx_interrupt,
  input  logic                       io_rx_interrupt,
  output logic                       rx_valid,
  output logic [SZ-1:0]              rx_addr,
  output logic [WSZ-1:0]             rx_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 bursts_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [7:0]          bursts_q, bursts_d;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level_q;
  logic [SZ+WSZ-1:0]   mem [DEPTH];
  logic [SZ+WSZ-1:0]   head;
  logic                push, accept, drive;

  assign dev_ready = (level_q != LW'(DEPTH));
  assign push      = dev_valid & dev_ready;
  assign accept    = (state_q == SEND) & ~io_rx_interrupt;
  assign head      = mem[rd_ptr];

  // NOTE: storage array has no reset; the level counter alone defines which entries are valid.
  always_ff @(posedge io_clk) begin
    if (push) mem[wr_ptr] <= {dev_addr, dev_data};
  end

  // NOTE: state uses non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge io_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (accept) rd_ptr <= rd_ptr + 1'b1;
      case ({push, accept})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge io_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      bursts_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      bursts_q <= bursts_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    bursts_d = bursts_q;
    case (state_q)
      IDLE: begin
        if (level_q >= LW'(4)) begin
          state_d = SEND;
          beat_d  = '0;
        end
      end
      SEND: begin
        if (accept) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d  = IDLE;
            bursts_d = bursts_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_w_notr       = (state_q == SEND);
  assign io_tx_interrupt = (state_q == SEND) && (beat_q == 2'd3);
  assign fifo_level      = level_q;
  assign bursts_sent     = bursts_q;

  // Combinational gate: the bus is released the instant the DMA claims it.
  assign drive   = io_w_notr & ~io_rx_interrupt;
  assign io_addr = drive ? head[SZ+WSZ-1:WSZ] : {SZ{1'bz}};
  assign io_data = drive ? head[WSZ-1:0]      : {WSZ{1'bz}};

  always_ff @(posedge io_clk or negedge rst) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      rx_addr  <= '0;
      rx_data  <= '0;
    end else begin
      rx_valid <= io_rx_interrupt;
      if (io_rx_interrupt) begin
        rx_addr <= io_addr;
        rx_data <= io_data;
      end
    end
  end

endmodule

// File: tb/tb_io_dma_port.sv
// Directed bench for io_dma_port: a cycle table for plain bursts plus hand-written
// sequences for DMA stalls, FIFO full and mid-burst reset.
module tb_io_dma_port;

  logic       io_clk = 1'b0;
  logic       rst;
  logic       dev_valid;
  logic       dev_ready;
  logic [7:0] dev_addr, dev_data;
  wire  [7:0] io_addr, io_data;
  logic       io_w_notr, io_tx_interrupt, io_rx_interrupt;
  logic       rx_valid;
  logic [7:0] rx_addr, rx_data;
  logic [3:0] fifo_level;
  logic [7:0] bursts_sent;

  logic       tb_drv;
  logic [7:0] tb_a, tb_d;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         wn_cycles = 0;

  assign io_addr = tb_drv ? tb_a : 8'hzz;
  assign io_data = tb_drv ? tb_d : 8'hzz;

  always #5 io_clk = ~io_clk;
  always @(negedge io_clk) if (io_w_notr) wn_cycles++;

  io_dma_port #(.SZ(8), .WSZ(8), .DEPTH(8)) dut (
    .io_clk(io_clk), .rst(rst),
    .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_addr(dev_addr), .dev_data(dev_data),
    .io_addr(io_addr), .io_data(io_data),
    .io_w_notr(io_w_notr), .io_tx_interrupt(io_tx_interrupt), .io_rx_interrupt(io_rx_interrupt),
    .rx_valid(rx_valid), .rx_addr(rx_addr), .rx_data(rx_data),
    .fifo_level(fifo_level), .bursts_sent(bursts_sent)
  );

  typedef struct {
    logic       dv;
    logic [7:0] da, dd;
    logic       exp_wn, exp_tx, exp_rdy;
    logic [3:0] exp_lvl;
    logic [7:0] exp_a, exp_d, exp_b;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    @(negedge io_clk);
  endtask

  task automatic push_word(input logic [7:0] a, input logic [7:0] d);
    dev_valid = 1'b1; dev_addr = a; dev_data = d;
    tick();
    dev_valid = 1'b0;
  endtask

  // When the port should be released, a zero probe from the bench must read back unchanged.
  task automatic check_bus(input string name, input logic wn, input logic [7:0] a, input logic [7:0] d);
    if (wn) begin
      check({name, " addr"}, 32'(io_addr), 32'(a));
      check({name, " data"}, 32'(io_data), 32'(d));
    end else begin
      tb_drv = 1'b1; tb_a = 8'h00; tb_d = 8'h00;
      #1;
      check({name, " released"}, 32'({io_addr, io_data}), 32'h0);
      tb_drv = 1'b0;
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fe_d [10];
    logic       fe_wn[10];
    logic       fe_tx[10];

    vecs[0]  = '{1, 8'h10, 8'hA0, 0, 0, 1, 1, 8'h00, 8'h00, 0};
    vecs[1]  = '{1, 8'h11, 8'hA1, 0, 0, 1, 2, 8'h00, 8'h00, 0};
    vecs[2]  = '{1, 8'h12, 8'hA2, 0, 0, 1, 3, 8'h00, 8'h00, 0};
    vecs[3]  = '{1, 8'h13, 8'hA3, 0, 0, 1, 4, 8'h00, 8'h00, 0};
    vecs[4]  = '{0, 8'h00, 8'h00, 1, 0, 1, 4, 8'h10, 8'hA0, 0};
    vecs[5]  = '{0, 8'h00, 8'h00, 1, 0, 1, 3, 8'h11, 8'hA1, 0};
    vecs[6]  = '{0, 8'h00, 8'h00, 1, 0, 1, 2, 8'h12, 8'hA2, 0};
    vecs[7]  = '{0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h13, 8'hA3, 0};
    vecs[8]  = '{0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 1};
    vecs[9]  = '{1, 8'h20, 8'hB0, 0, 0, 1, 1, 8'h00, 8'h00, 1};
    vecs[10] = '{1, 8'h21, 8'hB1, 0, 0, 1, 2, 8'h00, 8'h00, 1};
    vecs[11] = '{1, 8'h22, 8'hB2, 0, 0, 1, 3, 8'h00, 8'h00, 1};
    vecs[12] = '{0, 8'h00, 8'h00, 0, 0, 1, 3, 8'h00, 8'h00, 1};
    vecs[13] = '{0, 8'h00, 8'h00, 0, 0, 1, 3, 8'h00, 8'h00, 1};
    vecs[14] = '{1, 8'h23, 8'hB3, 0, 0, 1, 4, 8'h00, 8'h00, 1};
    vecs[15] = '{0, 8'h00, 8'h00, 1, 0, 1, 4, 8'h20, 8'hB0, 1};
    vecs[16] = '{0, 8'h00, 8'h00, 1, 0, 1, 3, 8'h21, 8'hB1, 1};
    vecs[17] = '{0, 8'h00, 8'h00, 1, 0, 1, 2, 8'h22, 8'hB2, 1};
    vecs[18] = '{0, 8'h00, 8'h00, 1, 1, 1, 1, 8'h23, 8'hB3, 1};
    vecs[19] = '{0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 2};

    fe_d  = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'h00};
    fe_wn = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    fe_tx = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    // Reset held with a peripheral word offered: nothing may be pushed.
    rst = 1'b0; dev_valid = 1'b1; dev_addr = 8'hEE; dev_data = 8'hEE;
    io_rx_interrupt = 1'b0; tb_drv = 1'b0; tb_a = 8'h00; tb_d = 8'h00;
    repeat (3) @(negedge io_clk);
    check("rst level", 32'(fifo_level), 32'd0);
    check("rst ready", 32'(dev_ready), 32'd1);
    check("rst w_notr", 32'(io_w_notr), 32'd0);
    check("rst tx_int", 32'(io_tx_interrupt), 32'd0);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst rx_addr", 32'(rx_addr), 32'd0);
    check("rst rx_data", 32'(rx_data), 32'd0);
    check("rst bursts", 32'(bursts_sent), 32'd0);
    check_bus("rst bus", 1'b0, 8'h00, 8'h00);
    rst = 1'b1; dev_valid = 1'b0;
    tick();
    check("post-rst level", 32'(fifo_level), 32'd0);
    check("post-rst ready", 32'(dev_ready), 32'd1);

    // Plain bursts, including the 3-words-wait case.
    for (int i = 0; i < 20; i++) begin
      dev_valid = vecs[i].dv; dev_addr = vecs[i].da; dev_data = vecs[i].dd;
      tick();
      dev_valid = 1'b0;
      check($sformatf("vec%0d w_notr", i), 32'(io_w_notr), 32'(vecs[i].exp_wn));
      check($sformatf("vec%0d tx_int", i), 32'(io_tx_interrupt), 32'(vecs[i].exp_tx));
      check($sformatf("vec%0d ready", i), 32'(dev_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d level", i), 32'(fifo_level), 32'(vecs[i].exp_lvl));
      check($sformatf("vec%0d bursts", i), 32'(bursts_sent), 32'(vecs[i].exp_b));
      check_bus($sformatf("vec%0d bus", i), vecs[i].exp_wn, vecs[i].exp_a, vecs[i].exp_d);
    end

    // DMA takes the bus for two cycles during beat 1.
    push_word(8'h30, 8'hC0); push_word(8'h31, 8'hC1);
    push_word(8'h32, 8'hC2); push_word(8'h33, 8'hC3);
    #1 wn_cycles = 0;
    tick();
    check_bus("stall beat0", 1'b1, 8'h30, 8'hC0);
    tick();
    check_bus("stall beat1", 1'b1, 8'h31, 8'hC1);
    check("stall level beat1", 32'(fifo_level), 32'd3);
    io_rx_interrupt = 1'b1; tb_drv = 1'b1; tb_a = 8'h55; tb_d = 8'h66;
    #1 check("rx1 bus", 32'({io_addr, io_data}), 32'h5566);
    tick();
    check("rx1 valid", 32'(rx_valid), 32'd1);
    check("rx1 captured", 32'({rx_addr, rx_data}), 32'h5566);
    check("rx1 level held", 32'(fifo_level), 32'd3);
    check("rx1 w_notr", 32'(io_w_notr), 32'd1);
    tb_a = 8'h56; tb_d = 8'h67;
    #1 check("rx2 bus", 32'({io_addr, io_data}), 32'h5667);
    tick();
    check("rx2 valid", 32'(rx_valid), 32'd1);
    check("rx2 captured", 32'({rx_addr, rx_data}), 32'h5667);
    check("rx2 level held", 32'(fifo_level), 32'd3);
    io_rx_interrupt = 1'b0; tb_drv = 1'b0;
    #1 check_bus("beat1 again", 1'b1, 8'h31, 8'hC1);
    tick();
    check("rx pulse end", 32'(rx_valid), 32'd0);
    check_bus("stall beat2", 1'b1, 8'h32, 8'hC2);
    tick();
    check_bus("stall beat3", 1'b1, 8'h33, 8'hC3);
    check("stall tx_int", 32'(io_tx_interrupt), 32'd1);
    tick();
    check("stall done w_notr", 32'(io_w_notr), 32'd0);
    check("stall done level", 32'(fifo_level), 32'd0);
    check("stall bursts", 32'(bursts_sent), 32'd3);
    #1 check("stall burst length", 32'(wn_cycles), 32'd6);

    // Fill the FIFO while the DMA holds the bus, then let two bursts drain it.
    io_rx_interrupt = 1'b1; tb_drv = 1'b1; tb_a = 8'h77; tb_d = 8'h88;
    for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i), 8'hD0 + 8'(i));
    check("full level", 32'(fifo_level), 32'd8);
    check("full ready", 32'(dev_ready), 32'd0);
    push_word(8'h48, 8'hD8);
    check("full reject level", 32'(fifo_level), 32'd8);
    check("full bursts held", 32'(bursts_sent), 32'd3);
    io_rx_interrupt = 1'b0; tb_drv = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      check($sformatf("drain%0d w_notr", i), 32'(io_w_notr), 32'(fe_wn[i]));
      check($sformatf("drain%0d tx_int", i), 32'(io_tx_interrupt), 32'(fe_tx[i]));
      check_bus($sformatf("drain%0d bus", i), fe_wn[i], fe_wn[i] ? 8'h40 + 8'(i - i / 5) : 8'h00, fe_d[i]);
    end
    check("drain level", 32'(fifo_level), 32'd0);
    check("drain bursts", 32'(bursts_sent), 32'd5);
    check("rx before reset", 32'({rx_addr, rx_data}), 32'h7788);

    // Asynchronous reset in the middle of a burst.
    push_word(8'h50, 8'hE0); push_word(8'h51, 8'hE1);
    push_word(8'h52, 8'hE2); push_word(8'h53, 8'hE3);
    tick(); tick(); tick();
    check_bus("pre-rst beat2", 1'b1, 8'h52, 8'hE2);
    rst = 1'b0;
    #1;
    check("mid-rst w_notr", 32'(io_w_notr), 32'd0);
    check("mid-rst tx_int", 32'(io_tx_interrupt), 32'd0);
    check("mid-rst level", 32'(fifo_level), 32'd0);
    check("mid-rst ready", 32'(dev_ready), 32'd1);
    check("mid-rst bursts", 32'(bursts_sent), 32'd0);
    check("mid-rst rx", 32'({rx_valid, rx_addr, rx_data}), 32'd0);
    check_bus("mid-rst bus", 1'b0, 8'h00, 8'h00);
    tick();
    rst = 1'b1;
    push_word(8'h60, 8'hF0); push_word(8'h61, 8'hF1); push_word(8'h62, 8'hF2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("3word wait%0d", i), 32'(io_w_notr), 32'd0);
    end
    check("3word level", 32'(fifo_level), 32'd3);
    push_word(8'h63, 8'hF3);
    check("4th word w_notr", 32'(io_w_notr), 32'd0);
    tick();
    check("post-rst start", 32'(io_w_notr), 32'd1);
    check_bus("post-rst head", 1'b1, 8'h60, 8'hF0);
    repeat (4) tick();
    check("post-rst bursts", 32'(bursts_sent), 32'd1);
    check("post-rst end level", 32'(fifo_level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
